// File: rtl/uart_imem_loader.sv
// Boot loader between the UART receiver and IMEM: packs bytes into little-endian words,
// writes them to consecutive addresses and holds the CPU in reset until the load completes.
module uart_imem_loader #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MAX_WORDS   = 2**ADDR_W,
  parameter logic [31:0] END_WORD    = 32'hFFFF_FFFF,
  parameter int unsigned GAP_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              loader_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              write_done,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned      CNT_W    = ADDR_W + 1;
  localparam int unsigned      GAP_W    = $clog2(GAP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [23:0]       asm_q, asm_d;
  logic [23:0]       asm_ins;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [31:0]       word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;

  // Partial word with the incoming byte dropped into its little-endian slot.
  always_comb begin
    asm_ins = asm_q;
    case (byte_cnt_q)
      2'd0:    asm_ins[7:0]   = rx_data;
      2'd1:    asm_ins[15:8]  = rx_data;
      default: asm_ins[23:16] = rx_data;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    gap_d      = '0;
    word_d     = word_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (loader_en) begin
          state_d    = S_COLLECT;
          cnt_d      = '0;
          byte_cnt_d = '0;
        end
      end

      S_COLLECT: begin
        if (!loader_en) begin
          state_d    = S_IDLE;
          byte_cnt_d = '0;
        end else if (rx_break) begin
          byte_cnt_d = '0;
        end else if (rx_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            word_d  = {rx_data, asm_q};
            state_d = S_CHECK;
          end else begin
            asm_d = asm_ins;
          end
        end else if (byte_cnt_q != 2'd0) begin
          // Stalled partial word: abandon it once the line has been quiet long enough.
          if (gap_q == GAP_LAST) begin
            byte_cnt_d = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end

      S_CHECK, S_WRITE: begin
        if (!loader_en) begin
          state_d    = S_IDLE;
          byte_cnt_d = '0;
        end else begin
          // Bytes keep landing in the assembler while the completed word is processed.
          if (rx_break) begin
            byte_cnt_d = '0;
          end else if (rx_valid) begin
            asm_d      = asm_ins;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end

          if (state_q == S_CHECK) begin
            if (word_q == END_WORD) begin
              state_d    = S_DONE;
              byte_cnt_d = '0;
            end else begin
              state_d = S_WRITE;
              addr_d  = cnt_q[ADDR_W-1:0];
              wdata_d = word_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == MAX_CNT) begin
              state_d    = S_DONE;
              byte_cnt_d = '0;
            end else begin
              state_d = S_COLLECT;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    we_d      = (state_d == S_WRITE);
    cpu_rst_d = (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      asm_q      <= '0;
      byte_cnt_q <= '0;
      gap_q      <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      gap_q      <= gap_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
    end
  end

  // Dropping loader_en suppresses a write strobe in the very cycle it falls.
  assign imem_we    = we_q & loader_en;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign write_done = done_q;
  assign word_count = cnt_q;

endmodule
